// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard producing Decode stalls and a busy mask.
// Optional long-latency (mul/div) tracking with WAW protection is enabled by defining MULDIV_TRACK_EN.
module hazard_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        issueValid,
    input  logic        issueRegWrite,
    input  logic [4:0]  issueRd,
    input  logic [1:0]  issueLat,
    input  logic        issueLong,
    input  logic [4:0]  rs1D,
    input  logic [4:0]  rs2D,
    input  logic        rs1Used,
    input  logic        rs2Used,
    input  logic        flushE,
    input  logic        wbLongValid,
    input  logic [4:0]  wbLongRd,
    output logic        stallD,
    output logic        issueAccept,
    output logic [31:0] busyMask
);
    logic [1:0]  cnt_q [1:31];
    logic [1:0]  cnt_d [1:31];
    logic [31:1] long_q, long_d;
    logic [31:0] long_vec;
    logic [4:0]  last_rd_q;
    logic        last_valid_q, last_valid_d;
    logic        rs_hazard, waw, issue_wr, long_set, kill;

    always_comb begin
        busyMask[0] = 1'b0;
        for (int r = 1; r < 32; r++) busyMask[r] = (cnt_q[r] != 2'd0) || long_q[r];
    end

    assign long_vec    = {long_q, 1'b0};
    assign rs_hazard   = (rs1Used && rs1D != 5'd0 && busyMask[rs1D]) ||
                         (rs2Used && rs2D != 5'd0 && busyMask[rs2D]);
    assign stallD      = issueValid && (rs_hazard || waw);
    assign issueAccept = issueValid && !stallD && !flushE;
    assign issue_wr    = issueAccept && issueRegWrite && issueRd != 5'd0;
    assign kill        = flushE && last_valid_q;

`ifdef MULDIV_TRACK_EN
    assign long_set = issueAccept && issueLong && issueRd != 5'd0;
    assign waw      = issueRegWrite && issueRd != 5'd0 && long_vec[issueRd];
`else
    logic unused_ok;
    assign unused_ok = ^{issueLong, wbLongValid, wbLongRd, long_vec[0]};
    assign long_set  = 1'b0;
    assign waw       = 1'b0;
`endif

    assign last_valid_d = issue_wr || long_set;

    // A flush kills only last cycle's destination; a new load overrides the decrement.
    always_comb begin
        for (int r = 1; r < 32; r++) begin
            cnt_d[r] = (kill && last_rd_q == 5'(r))     ? 2'd0 :
                       (issue_wr && issueRd == 5'(r))  ? issueLat :
                       (cnt_q[r] != 2'd0)              ? cnt_q[r] - 2'd1 : 2'd0;
`ifdef MULDIV_TRACK_EN
            long_d[r] = (long_q[r] && !(wbLongValid && wbLongRd == 5'(r)) && !(kill && last_rd_q == 5'(r))) ||
                        (long_set && issueRd == 5'(r));
`else
            long_d[r] = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < 32; r++) cnt_q[r] <= 2'd0;
            long_q       <= '0;
            last_valid_q <= 1'b0;
            last_rd_q    <= 5'd0;
        end else begin
            cnt_q        <= cnt_d;
            long_q       <= long_d;
            last_valid_q <= last_valid_d;
            last_rd_q    <= issueRd;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus random traffic checked against a ready-time reference model.
module tb_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        rst, issueValid, issueRegWrite, issueLong, rs1Used, rs2Used, flushE, wbLongValid;
    logic [4:0]  issueRd, rs1D, rs2D, wbLongRd;
    logic [1:0]  issueLat;
    logic        stallD, issueAccept;
    logic [31:0] busyMask;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .issueValid(issueValid), .issueRegWrite(issueRegWrite),
        .issueRd(issueRd), .issueLat(issueLat), .issueLong(issueLong),
        .rs1D(rs1D), .rs2D(rs2D), .rs1Used(rs1Used), .rs2Used(rs2Used),
        .flushE(flushE), .wbLongValid(wbLongValid), .wbLongRd(wbLongRd),
        .stallD(stallD), .issueAccept(issueAccept), .busyMask(busyMask)
    );

    always #5 clk = ~clk;

    // Model: each register is busy while the cycle number is below its ready time.
    int cyc = 0;
    int ready [32];
    bit lng [32];
    bit last_v;
    int last_rd;
    int passed = 0, total = 0;

    function automatic bit mbusy(int r);
        return r != 0 && (cyc < ready[r] || lng[r]);
    endfunction

    function automatic bit mstall();
        bit w = 1'b0;
`ifdef MULDIV_TRACK_EN
        w = issueRegWrite && issueRd != 0 && lng[issueRd];
`endif
        return issueValid && ((rs1Used && mbusy(int'(rs1D))) || (rs2Used && mbusy(int'(rs2D))) || w);
    endfunction

    function automatic logic [31:0] mmask();
        logic [31:0] m = '0;
        for (int r = 0; r < 32; r++) m[r] = mbusy(r);
        return m;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic drv(bit v, bit w, int rd, int lat, bit u1, int r1, bit u2, int r2, bit fl);
        rst = 0; issueValid = v; issueRegWrite = w; issueRd = 5'(rd); issueLat = 2'(lat);
        rs1Used = u1; rs1D = 5'(r1); rs2Used = u2; rs2D = 5'(r2); flushE = fl;
        issueLong = 0; wbLongValid = 0; wbLongRd = 0;
    endtask

    task automatic tick();
        bit acc, lg;
        acc = mstall() ? 1'b0 : (issueValid && !flushE);
        chk("stallD", 32'(stallD), 32'(mstall()));
        chk("issueAccept", 32'(issueAccept), 32'(acc));
        chk("busyMask", busyMask, mmask());
        @(posedge clk);
        lg = 1'b0;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin ready[r] = 0; lng[r] = 0; end
            last_v = 0;
        end else begin
            if (flushE && last_v) begin ready[last_rd] = cyc + 1; lng[last_rd] = 0; end
`ifdef MULDIV_TRACK_EN
            if (wbLongValid) lng[wbLongRd] = 0;
            lg = acc && issueLong && issueRd != 0;
            if (lg) lng[issueRd] = 1;
`endif
            if (acc && issueRegWrite && issueRd != 0) ready[issueRd] = cyc + 1 + int'(issueLat);
            last_v = (acc && issueRegWrite && issueRd != 0) || lg;
            last_rd = int'(issueRd);
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin ready[r] = 0; lng[r] = 0; end
        last_v = 0; last_rd = 0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        @(negedge clk); tick(); rst = 1; #1; tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("reset_mask", busyMask, 32'h0);
        tick();
        // load-use, latency 1
        drv(1, 1, 5, 1, 0, 0, 0, 0, 0); #1; chk("r21_acc", 32'(issueAccept), 1); tick();
        drv(1, 0, 0, 0, 1, 5, 0, 0, 0); #1; chk("r21_stall", 32'(stallD), 1); chk("r21_bm5", 32'(busyMask[5]), 1); tick();
        #1; chk("r21_nostall", 32'(stallD), 0); chk("r21_acc2", 32'(issueAccept), 1); chk("r21_bm5_clr", 32'(busyMask[5]), 0); tick();
        // latency 2
        drv(1, 1, 7, 2, 0, 0, 0, 0, 0); #1; tick();
        drv(1, 0, 0, 0, 0, 0, 1, 7, 0); #1; chk("r22_stall1", 32'(stallD), 1); tick();
        #1; chk("r22_stall2", 32'(stallD), 1); tick();
        #1; chk("r22_acc", 32'(issueAccept), 1); tick();
        // rd=0 never tracked
        drv(1, 1, 0, 3, 0, 0, 0, 0, 0); #1; tick();
        drv(1, 0, 0, 0, 1, 0, 0, 0, 0); #1; chk("r23_stall", 32'(stallD), 0); chk("r23_mask", busyMask, 0); tick();
        // flush kills last issue and suppresses current
        drv(1, 1, 9, 2, 0, 0, 0, 0, 0); #1; tick();
        drv(1, 1, 10, 3, 0, 0, 0, 0, 1); #1; chk("r24_acc", 32'(issueAccept), 0); chk("r24_bm9", 32'(busyMask[9]), 1); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); #1; chk("r24_bm9_clr", 32'(busyMask[9]), 0); chk("r24_bm10", 32'(busyMask[10]), 0); tick();
        // flush with no prior accepted issue leaves older entries
        drv(1, 1, 11, 3, 0, 0, 0, 0, 0); #1; tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); #1; tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1); #1; tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); #1; chk("old_entry_kept", 32'(busyMask[11]), 1); tick();
`ifdef MULDIV_TRACK_EN
        drv(1, 1, 12, 0, 0, 0, 0, 0, 0); issueLong = 1; #1; tick();
        for (int i = 0; i < 6; i++) begin
            drv(1, 0, 0, 0, 1, 12, 0, 0, 0); #1; chk("r25_hold", 32'(stallD), 1); tick();
        end
        drv(1, 1, 12, 1, 0, 0, 0, 0, 0); #1; chk("r25_waw", 32'(stallD), 1); tick();
        drv(1, 0, 0, 0, 1, 12, 0, 0, 0); wbLongValid = 1; wbLongRd = 12; #1; chk("r25_wb_cyc", 32'(stallD), 1); tick();
        drv(1, 1, 12, 1, 1, 12, 0, 0, 0); #1; chk("r25_release", 32'(stallD), 0); tick();
        drv(1, 1, 4, 0, 0, 0, 0, 0, 0); issueLong = 1; #1; tick();
`endif
        // reset mid-operation
        drv(1, 1, 3, 3, 0, 0, 0, 0, 0); #1; tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); #1; chk("r26_bm3", 32'(busyMask[3]), 1); rst = 1; tick();
        drv(1, 0, 0, 0, 1, 3, 1, 4, 0); #1; chk("r26_mask", busyMask, 0); chk("r26_stall", 32'(stallD), 0); tick();
        // random traffic
        for (int i = 0; i < 400; i++) begin
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15),
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 15),
                $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 7) == 0);
            issueLong = $urandom_range(0, 7) == 0;
            wbLongValid = $urandom_range(0, 3) == 0;
            wbLongRd = 5'($urandom_range(0, 15));
            rst = $urandom_range(0, 59) == 0;
            #1; tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
